temp_sensor_axi_slave: RTL and testbench
========================================

Name: temp_sensor_axi_slave

Overview:
AXI4-Lite responder (slave) for the Temp_Sensor IP. It terminates transactions issued by the system AXI4-Lite master (PS or BFM). It exposes four read/write scratch/control registers, a read-only latched temperature sample register, and a read-only ID register. It sits between the AXI interconnect and the temperature-sensor front end, and drives control bits out of register 0.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots.
C_TEMP_WIDTH, 16, width of the temperature sample input.
C_ID_VALUE, 32'h7E3D_0100, constant returned by the ID register.

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accepted
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accepted
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  master ready for response
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accepted
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  master ready for read data
temp_data  in  C_TEMP_WIDTH  sample from the sensor front end
temp_valid  in  1  one-cycle strobe; temp_data is valid
ctrl_out  out  32  current contents of REG0

Behaviour:
- Register map (word index = ADDR[4:2]; ADDR[1:0] ignored):
  - 0–3: REG0–REG3, RW.
  - 4: TEMP, RO. Holds {sample_count[15:0], zero-extended temp_data}.
  - 5: ID, RO.
  - 6–7: unmapped.
- Reset (ARESET=1 at a clock edge):
  - All READY/VALID outputs go to 0; BRESP=RRESP=0; RDATA=0.
  - REG0–3, TEMP and sample_count go to 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- Write channel, two states (W_IDLE, W_RESP):
  - In W_IDLE, when AWVALID & WVALID are both high: AWREADY and WREADY pulse high together for exactly one cycle. The write is performed at that edge. Next cycle: BVALID=1 and state = W_RESP.
  - AW without W, or W without AW: no handshake; wait for both.
  - In W_RESP, BVALID is held with BRESP stable until BREADY=1; then BVALID=0 on the next cycle and state returns to W_IDLE. No new write is accepted while BVALID=1.
  - WSTRB[i] enables byte i; bytes with a 0 strobe are unchanged.
  - Writes to TEMP, ID or unmapped slots change nothing and return BRESP=2'b10 (SLVERR). REG0–3 writes return 2'b00 (OKAY).
- Read channel, two states (R_IDLE, R_DATA):
  - In R_IDLE, when ARVALID=1: ARREADY pulses for one cycle. RDATA/RRESP are registered at that edge. Next cycle: RVALID=1.
  - RDATA/RRESP are held stable until RREADY=1; then RVALID drops the next cycle.
  - Unmapped reads return RDATA=0 with RRESP=SLVERR.
  - Read latency is one cycle from the ARREADY handshake.
- Read and write channels are independent. When both hit the same register in the same cycle, the read returns the pre-write value.
- TEMP capture:
  - On temp_valid=1, TEMP[C_TEMP_WIDTH-1:0] <= temp_data and sample_count increments.
  - sample_count wraps from 0xFFFF to 0.
  - A read of TEMP coinciding with temp_valid returns the old value.
- ctrl_out is REG0 directly, so it updates the cycle after the write handshake.

Test Plan:
1. Reset, then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00, 0x04, 0x08, 0x0C. Read each back -> data matches, BRESP=RRESP=OKAY, ctrl_out=0x0101FFFF.
2. Write 0x12345678 to 0x04 with WSTRB=4'b0101 over existing 0xABCD0001 -> readback 0xAB340078.
3. Drive AWVALID for 3 cycles before WVALID; hold BREADY low for 4 cycles -> AWREADY/WREADY pulse only when both valids are high; BVALID stays high with stable BRESP until BREADY.
4. Pulse temp_valid with temp_data=0x0ABC twice, then read 0x10 -> 0x00020ABC. Read 0x14 -> C_ID_VALUE. Write 0x10 -> SLVERR and TEMP unchanged. Read 0x18 -> 0, SLVERR.
5. Issue simultaneous write 0x55AA55AA and read to 0x08 (old value 0xDEAD0011) -> read returns 0xDEAD0011; a following read returns 0x55AA55AA.
6. Assert ARESET while RVALID=1 and RREADY=0 -> RVALID=0 next cycle and REG0–3 read 0 afterwards.

Source files
------------

// File: rtl/temp_sensor_axi_slave.sv
// temp_sensor_axi_slave: AXI4-Lite slave with four RW registers, latched temperature sample and ID register
`timescale 1ns/1ps
module temp_sensor_axi_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          C_TEMP_WIDTH       = 16,
  parameter logic [31:0] C_ID_VALUE         = 32'h7E3D_0100
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_TEMP_WIDTH-1:0]         temp_data,
  input  logic                            temp_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic                          wr_hs, rd_hs;
  logic [2:0]                    wr_idx, rd_idx;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic                          rd_err;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_d [4];
  logic [C_TEMP_WIDTH-1:0]       temp_q, temp_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic                          unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign ctrl_out = reg_q[0];
  // write channel state register
  always_ff @(posedge ACLK) begin
    w_state_q <= ARESET ? W_IDLE : w_state_d;
  end
  // write channel next state: accept only when both address and data are present
  always_comb begin
    w_state_d = (w_state_q == W_IDLE) ? (wr_hs ? W_RESP : W_IDLE) : (S_AXI_BREADY ? W_IDLE : W_RESP);
  end
  // write channel outputs: ready pulses in the accepting cycle, response held in W_RESP
  always_comb begin
    wr_hs         = !ARESET && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    S_AXI_AWREADY = wr_hs;
    S_AXI_WREADY  = wr_hs;
    S_AXI_BVALID  = (w_state_q == W_RESP);
    S_AXI_BRESP   = bresp_q;
  end
  // read channel state register
  always_ff @(posedge ACLK) begin
    r_state_q <= ARESET ? R_IDLE : r_state_d;
  end
  // read channel next state
  always_comb begin
    r_state_d = (r_state_q == R_IDLE) ? (rd_hs ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
  end
  // read channel outputs
  always_comb begin
    rd_hs         = !ARESET && (r_state_q == R_IDLE) && S_AXI_ARVALID;
    S_AXI_ARREADY = rd_hs;
    S_AXI_RVALID  = (r_state_q == R_DATA);
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = rresp_q;
  end
  // read mux over current register values, so a same-cycle write is not visible
  always_comb begin
    rd_word = !rd_idx[2] ? reg_q[rd_idx[1:0]] :
              (rd_idx == 3'd4) ? {cnt_q, 16'(temp_q)} :
              (rd_idx == 3'd5) ? C_ID_VALUE : '0;
    rd_err  = rd_idx[2] && rd_idx[1];
    rdata_d = rd_hs ? rd_word : rdata_q;
    rresp_d = rd_hs ? (rd_err ? SLVERR : OKAY) : rresp_q;
    bresp_d = wr_hs ? (wr_idx[2] ? SLVERR : OKAY) : bresp_q;
  end
  // byte-masked update of the RW registers; other slots are read-only or unmapped
  always_comb begin
    for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];
    if (wr_hs && !wr_idx[2])
      for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
        if (S_AXI_WSTRB[b]) reg_d[wr_idx[1:0]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
  end
  // temperature capture and wrapping sample counter
  always_comb begin
    temp_d = temp_valid ? temp_data : temp_q;
    cnt_d  = temp_valid ? cnt_q + 16'd1 : cnt_q;
  end
  // datapath registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg_q   <= '{default: '0};
      temp_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= OKAY;
      bresp_q <= OKAY;
    end else begin
      reg_q   <= reg_d;
      temp_q  <= temp_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end
endmodule

// File: tb/tb_temp_sensor_axi_slave.sv
// tb_temp_sensor_axi_slave: directed bench with a register-map model for temp_sensor_axi_slave
`timescale 1ns/1ps
module tb_temp_sensor_axi_slave;
  localparam logic [31:0] ID = 32'h7E3D_0100;
  logic        ACLK = 0, ARESET = 1;
  logic [4:0]  AWADDR = 0, ARADDR = 0;
  logic [2:0]  AWPROT = 0, ARPROT = 0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic [31:0] WDATA = 0;
  logic [3:0]  WSTRB = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, ctrl_out;
  logic [15:0] temp_data = 0;
  logic        temp_valid = 0;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_reg [4];
  logic [15:0] m_temp = 0, m_cnt = 0;
  logic [31:0] exp_rdata = 0;
  logic [1:0]  exp_rresp = 0, exp_bresp = 0;
  logic [31:0] d;
  logic [1:0]  r, br;
  logic [31:0] t1_data [4];

  temp_sensor_axi_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .temp_data(temp_data), .temp_valid(temp_valid), .ctrl_out(ctrl_out)
  );

  always #5 ACLK = ~ACLK;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [33:0] m_read(logic [4:0] a);
    case (a[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: return {2'b00, m_reg[a[3:2]]};
      3'd4:    return {2'b00, m_cnt, m_temp};
      3'd5:    return {2'b00, ID};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  function automatic void m_write(logic [4:0] a, logic [31:0] v, logic [3:0] s);
    exp_bresp = a[4] ? 2'b10 : 2'b00;
    if (!a[4])
      for (int b = 0; b < 4; b++) if (s[b]) m_reg[a[3:2]][8*b +: 8] = v[8*b +: 8];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_temp = 0;
    m_cnt = 0;
  endfunction

  always @(negedge ACLK) if (!ARESET) begin
    chk("ctrl_out", ctrl_out, m_reg[0]);
    chk("aw_w_ready_pair", 32'(AWREADY), 32'(WREADY));
    if (RVALID) begin
      chk("rdata", RDATA, exp_rdata);
      chk("rresp", 32'(RRESP), 32'(exp_rresp));
    end
    if (BVALID) chk("bresp", 32'(BRESP), 32'(exp_bresp));
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] v, input logic [3:0] s,
                           input int hold, output logic [1:0] resp);
    int n = 0;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = v; WSTRB = s; AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("aw_handshake", 32'(AWREADY & WREADY), 1);
    @(posedge ACLK);
    m_write(a, v, s);
    #1;
    if (hold == 0) begin AWVALID = 0; WVALID = 0; end
    @(negedge ACLK);
    chk("bvalid_rise", 32'(BVALID), 1);
    chk("aw_pulse_one_cycle", 32'(AWREADY), 0);
    resp = BRESP;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      chk("bvalid_hold", 32'(BVALID), 1);
      chk("no_accept_in_resp", 32'(AWREADY | WREADY), 0);
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    @(posedge ACLK); #1 BREADY = 0;
    @(negedge ACLK);
    chk("bvalid_fall", 32'(BVALID), 0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] v, output logic [1:0] resp);
    int n = 0;
    logic [33:0] e;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("ar_handshake", 32'(ARREADY), 1);
    e = m_read(a);
    exp_rdata = e[31:0];
    exp_rresp = e[33:32];
    @(posedge ACLK); #1 ARVALID = 0;
    @(negedge ACLK);
    chk("rvalid_rise", 32'(RVALID), 1);
    v = RDATA;
    resp = RRESP;
    RREADY = 1;
    @(posedge ACLK); #1 RREADY = 0;
    @(negedge ACLK);
    chk("rvalid_fall", 32'(RVALID), 0);
  endtask

  task automatic temp_pulse(input logic [15:0] t);
    @(posedge ACLK); #1;
    temp_data = t; temp_valid = 1;
    @(posedge ACLK);
    m_temp = t;
    m_cnt = m_cnt + 16'd1;
    #1 temp_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    t1_data[0] = 32'h0101FFFF; t1_data[1] = 32'hABCD0001;
    t1_data[2] = 32'hDEAD0011; t1_data[3] = 32'hBEEF0011;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_handshakes", 32'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 0);
    chk("reset_rdata", RDATA, 0);
    chk("reset_resp", 32'({BRESP, RRESP}), 0);
    chk("reset_ctrl_out", ctrl_out, 0);
    @(posedge ACLK); #1 ARESET = 0;

    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), t1_data[i], 4'hF, 0, br);
      chk("t1_bresp", 32'(br), 0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), d, r);
      chk("t1_readback", d, t1_data[i]);
      chk("t1_rresp", 32'(r), 0);
    end
    chk("t1_ctrl_out", ctrl_out, 32'h0101FFFF);

    axi_write(5'h04, 32'h12345678, 4'b0101, 0, br);
    axi_read(5'h04, d, r);
    chk("t2_strobe", d, 32'hAB340078);

    @(posedge ACLK); #1;
    AWADDR = 5'h0C; WDATA = 32'hCAFE0033; WSTRB = 4'hF; AWVALID = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t3_aw_only_no_hs", 32'(AWREADY | WREADY), 0);
    end
    @(posedge ACLK); #1 AWVALID = 0; WVALID = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk("t3_w_only_no_hs", 32'(AWREADY | WREADY), 0);
    end
    @(posedge ACLK); #1 WVALID = 0; AWVALID = 1;
    axi_write(5'h0C, 32'hCAFE0033, 4'hF, 4, br);
    chk("t3_bresp", 32'(br), 0);
    axi_read(5'h0C, d, r);
    chk("t3_readback", d, 32'hCAFE0033);

    temp_pulse(16'h0ABC);
    temp_pulse(16'h0ABC);
    axi_read(5'h10, d, r);
    chk("t4_temp", d, 32'h00020ABC);
    axi_read(5'h14, d, r);
    chk("t4_id", d, ID);
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, br);
    chk("t4_temp_wr_slverr", 32'(br), 2);
    axi_write(5'h14, 32'h0, 4'hF, 0, br);
    chk("t4_id_wr_slverr", 32'(br), 2);
    axi_read(5'h10, d, r);
    chk("t4_temp_unchanged", d, 32'h00020ABC);
    axi_read(5'h18, d, r);
    chk("t4_unmapped_data", d, 0);
    chk("t4_unmapped_resp", 32'(r), 2);
    axi_read(5'h1C, d, r);
    chk("t4_unmapped7_resp", 32'(r), 2);
    fork
      axi_read(5'h10, d, r);
      temp_pulse(16'h1234);
    join
    chk("t4_temp_coincident_old", d, 32'h00020ABC);
    axi_read(5'h10, d, r);
    chk("t4_temp_new", d, 32'h00031234);

    fork
      axi_write(5'h08, 32'h55AA55AA, 4'hF, 0, br);
      axi_read(5'h08, d, r);
    join
    chk("t5_read_old", d, 32'hDEAD0011);
    axi_read(5'h08, d, r);
    chk("t5_read_new", d, 32'h55AA55AA);

    @(posedge ACLK); #1;
    ARADDR = 5'h00; ARVALID = 1;
    @(negedge ACLK);
    exp_rdata = m_reg[0];
    exp_rresp = 0;
    @(posedge ACLK); #1 ARVALID = 0;
    @(negedge ACLK);
    chk("t6_rvalid_before", 32'(RVALID), 1);
    ARESET = 1;
    @(posedge ACLK);
    m_reset();
    #1 ARESET = 0;
    @(negedge ACLK);
    chk("t6_rvalid_dropped", 32'(RVALID), 0);
    chk("t6_rdata_cleared", RDATA, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), d, r);
      chk("t6_reg_cleared", d, 0);
    end
    axi_read(5'h10, d, r);
    chk("t6_temp_cleared", d, 0);
    chk("t6_ctrl_out", ctrl_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
